// File: rtl/altro_rdo_pkg.sv
`default_nettype none
// ============================================================================
// altro_rdo_pkg : shared types and trailer layout for the ALTRO readout capture
// Rev 1.0
// ============================================================================
package altro_rdo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } rdo_state_t;

  localparam logic [13:0] TRAILER_MARK_DEFAULT = 14'h2AAA;

  localparam int ERR_MARK = 0;
  localparam int ERR_ADDR = 1;
  localparam int ERR_WC   = 2;
  localparam int ERR_OVF  = 3;

  localparam int TRL_MARK_HI = 39;
  localparam int TRL_MARK_LO = 26;
  localparam int TRL_WC_HI   = 25;
  localparam int TRL_WC_LO   = 16;
  localparam int TRL_NIB_HI  = 15;
  localparam int TRL_NIB_LO  = 12;
  localparam int TRL_HW_HI   = 11;
  localparam int TRL_HW_LO   = 0;

  localparam logic [3:0] TRL_NIBBLE = 4'hA;

endpackage
`default_nettype wire

// File: rtl/altro_trailer_chk.sv
`default_nettype none
// ============================================================================
// altro_trailer_chk : combinational check of the closing trailer word
// Rev 1.0
// ============================================================================
module altro_trailer_chk
  import altro_rdo_pkg::*;
#(
  parameter int          ADDR_W       = 8,
  parameter logic [13:0] TRAILER_MARK = TRAILER_MARK_DEFAULT
) (
  input  logic [39:0]     last_word,
  input  logic [4:0]      fee_addr,
  input  logic [6:0]      rdo_addr,
  input  logic [ADDR_W:0] words,
  output logic [2:0]      err
);

  logic        no_words;
  logic [31:0] payload_words;
  logic [31:0] wc_words;

  assign no_words      = (words == '0);
  assign payload_words = 32'(words) - 32'd1;
  // wc10 counts 10-bit samples; four samples pack into one 40-bit word
  assign wc_words      = (32'(last_word[TRL_WC_HI:TRL_WC_LO]) + 32'd3) >> 2;

  always_comb begin
    err = '0;
    err[ERR_MARK] = no_words
                  || (last_word[TRL_MARK_HI:TRL_MARK_LO] != TRAILER_MARK)
                  || (last_word[TRL_NIB_HI:TRL_NIB_LO] != TRL_NIBBLE);
    err[ERR_ADDR] = !no_words
                  && (last_word[TRL_HW_HI:TRL_HW_LO] != {fee_addr, rdo_addr});
    err[ERR_WC]   = no_words || (payload_words != wc_words);
  end

endmodule
`default_nettype wire

// File: rtl/altro_rdo_capture.sv
`default_nettype none
// ============================================================================
// altro_rdo_capture : captures ALTRO channel payload into the readout RAM.
// Optional trailer checking under macro RDO_TRAILER_CHK_EN.    Rev 1.0
// ============================================================================
module altro_rdo_capture
  import altro_rdo_pkg::*;
#(
  parameter int          ADDR_W       = 8,
  parameter logic [13:0] TRAILER_MARK = TRAILER_MARK_DEFAULT
) (
  input  logic              rdoclk_n,
  input  logic              reset,
  input  logic [39:0]       bd_in,
  input  logic              dstbn,
  input  logic              trsfn,
  input  logic              altro_chrdo_en,
  input  logic              ram_addrclr,
  input  logic [4:0]        fee_addr,
  input  logic [6:0]        rdo_addr,
  input  logic              ch_ack,
  input  logic              err_clr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [39:0]       ram_wdata,
  output logic              ch_done,
  output logic [ADDR_W:0]   ch_words,
  output logic [3:0]        ch_err,
  output logic              con_busy,
  output logic [3:0]        err_sticky,
  output logic [15:0]       err_cnt
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  rdo_state_t      state, state_nxt;
  logic [39:0]     bd_q;
  logic            dstbn_q, trsfn_q;
  logic [ADDR_W:0] word_cnt;
  logic            ovf;
  logic [39:0]     last_word;
  logic [2:0]      trl_err;
  logic [3:0]      err_nxt, err_q;
  logic            strobe, accept;

  assign ram_wdata = bd_q;

`ifdef RDO_TRAILER_CHK_EN
  altro_trailer_chk #(
    .ADDR_W       (ADDR_W),
    .TRAILER_MARK (TRAILER_MARK)
  ) u_trailer_chk (
    .last_word (last_word),
    .fee_addr  (fee_addr),
    .rdo_addr  (rdo_addr),
    .words     (word_cnt),
    .err       (trl_err)
  );
`else
  logic unused_trl;
  assign unused_trl = ^{last_word, fee_addr, rdo_addr, TRAILER_MARK};
  assign trl_err    = '0;
`endif

  always_comb begin
    err_nxt          = '0;
    err_nxt[ERR_MARK] = trl_err[ERR_MARK];
    err_nxt[ERR_ADDR] = trl_err[ERR_ADDR];
    err_nxt[ERR_WC]   = trl_err[ERR_WC];
    err_nxt[ERR_OVF]  = ovf;
  end

  always_ff @(posedge rdoclk_n) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
    accept    = 1'b0;
    ram_we    = 1'b0;
    ch_done   = 1'b0;
    ch_words  = '0;
    ch_err    = '0;
    case (state)
      IDLE: if (altro_chrdo_en && !trsfn_q) state_nxt = XFER;
      XFER: begin
        if (!altro_chrdo_en) begin
          state_nxt = IDLE;
        end else begin
          strobe = !dstbn_q;
          accept = strobe && (word_cnt != FULL_CNT);
          ram_we = accept;
          if (trsfn_q) state_nxt = CHECK;
        end
      end
      CHECK: state_nxt = altro_chrdo_en ? DONE : IDLE;
      DONE: begin
        ch_done   = 1'b1;
        ch_words  = word_cnt;
        ch_err    = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rdoclk_n) begin
    if (reset) begin
      bd_q       <= '0;
      dstbn_q    <= 1'b1;
      trsfn_q    <= 1'b1;
      ram_waddr  <= '0;
      word_cnt   <= '0;
      ovf        <= 1'b0;
      last_word  <= '0;
      err_q      <= '0;
      con_busy   <= 1'b0;
      err_sticky <= '0;
      err_cnt    <= '0;
    end else begin
      bd_q    <= bd_in;
      dstbn_q <= dstbn;
      trsfn_q <= trsfn;

      if (ram_addrclr && state != XFER) begin
        ram_waddr <= '0;
        word_cnt  <= '0;
        ovf       <= 1'b0;
      end else if (accept) begin
        word_cnt  <= word_cnt + 1'b1;
        last_word <= bd_q;
        // hold on the last location instead of wrapping onto word 0
        if (ram_waddr != '1) ram_waddr <= ram_waddr + 1'b1;
      end else if (strobe) begin
        ovf <= 1'b1;
      end

      if (state == CHECK) err_q <= err_nxt;

      if (state == DONE) con_busy <= 1'b1;
      else if (ch_ack)   con_busy <= 1'b0;

      if (err_clr) begin
        err_sticky <= '0;
        err_cnt    <= '0;
      end else if (state == DONE) begin
        err_sticky <= err_sticky | err_q;
        if (err_q != '0 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/altro_rdo_capture.md
Name: altro_rdo_capture

Overview:
- Downstream of the ALTRO bus-interface FSM: captures the channel payload the ALTROs return on bd[39:0] during a readout transfer (trsfn low, qualified by dstbn).
- Writes each 40-bit word into the per-channel readout RAM and checks the closing trailer word.
- Drives con_busy back to the bus-interface FSM so the next channel-readout command waits until the consumer has drained the current channel.

Parameters:
- ADDR_W, 8: channel RAM address width. Depth = 2^ADDR_W 40-bit words.
- TRAILER_MARK, 14'h2AAA: required value of trailer bits [39:26].

Ports:
- rdoclk_n  in  1  capture clock (inverted rdoclk). All logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- bd_in  in  40  ALTRO bus, read direction.
- dstbn  in  1  data strobe, active-low; one word per low cycle.
- trsfn  in  1  transfer window, active-low.
- altro_chrdo_en  in  1  readout sequence active; low aborts capture.
- ram_addrclr  in  1  new channel command issued; clears the write address.
- fee_addr  in  5  FEE address, used for the trailer check.
- rdo_addr  in  7  ALTRO/channel hardware address of the channel being read.
- ch_ack  in  1  consumer pulse: channel RAM drained.
- err_clr  in  1  clears the sticky error and the error counter.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  40  RAM write data.
- ch_done  out  1  one-cycle pulse: channel captured.
- ch_words  out  ADDR_W+1  number of 40-bit words captured, trailer included. Valid with ch_done.
- ch_err  out  4  error flags, valid with ch_done.
- con_busy  out  1  channel pending in RAM.
- err_sticky  out  4  OR of all ch_err since err_clr.
- err_cnt  out  16  saturating count of channels with ch_err != 0.

Behaviour:
- Reset values: every output 0; state IDLE; ram_waddr 0.
- Input registering: bd_in, dstbn and trsfn are registered once (bd_q, dstbn_q, trsfn_q). All decisions use the registered copies.
- Write latency: a RAM write occurs one cycle after the strobe was sampled.
- ram_addrclr (any state except XFER): ram_waddr <= 0, word counter <= 0, ovf <= 0.
- IDLE:
  - Go to XFER when altro_chrdo_en=1 and trsfn_q=0.
- XFER:
  - Each cycle with dstbn_q=0: ram_we=1, ram_wdata=bd_q, ram_waddr increments, word counter increments, last-word register <= bd_q.
  - Overflow: when the counter equals 2^ADDR_W, further writes are suppressed (ram_we=0) and ovf is set. The address does not wrap.
  - On trsfn_q=1, go to CHECK. If dstbn_q=0 in that same cycle, the word is still written and counted.
- CHECK (one cycle). Compute ch_err from the last word, trailer field layout [39:26] mark, [25:16] wc10, [15:12] 4'hA, [11:0] hw addr:
  - bit0: [39:26] != TRAILER_MARK or [15:12] != 4'hA.
  - bit1: [11:0] != {fee_addr, rdo_addr}.
  - bit2: (words-1) != ceil(wc10/4).
  - bit3: ovf.
  - Zero words captured sets bit0 and bit2.
  - Then go to DONE.
- DONE (one cycle):
  - ch_done=1, ch_words=counter.
  - con_busy <= 1.
  - err_sticky |= ch_err.
  - err_cnt increments (saturating at 16'hFFFF) if ch_err != 0.
  - Go to IDLE.
- con_busy: cleared on ch_ack. If ch_ack coincides with DONE, set wins.
- Abort: altro_chrdo_en=0 in XFER or CHECK returns to IDLE with no ch_done. Partial RAM contents are ignored; the next ram_addrclr discards them.
- Transfer timeout: this block has no timeout of its own. If trsfn never rises, the bus-interface FSM returns to its command loop and the next ram_addrclr is ignored while in XFER. Dropping altro_chrdo_en at end of sequence recovers the block.
- err_clr: clears err_sticky and err_cnt. If it coincides with DONE, err_clr wins for that cycle.
- Reset mid-transfer: immediate return to IDLE, outputs zeroed, no ch_done.

Optional Feature:
- Macro: RDO_TRAILER_CHK_EN.
- Defined: ch_err bits 0-2 are computed as above.
- Undefined: bits 0-2 are forced to 0 and the comparators are not built. Only the overflow flag (bit3) remains. CHECK still lasts one cycle, so latency is identical.

Decomposition:
- Package altro_rdo_pkg holds:
  - state enum {IDLE, XFER, CHECK, DONE};
  - TRAILER_MARK default;
  - ch_err bit-index constants ERR_MARK=0, ERR_ADDR=1, ERR_WC=2, ERR_OVF=3;
  - the trailer field slice constants.
- One sub-module, altro_trailer_chk: combinational last-word/expected-address/word-count comparator. It is excluded when RDO_TRAILER_CHK_EN is undefined.

Test Plan:
- Good channel: fee_addr=5'h3, rdo_addr=7'h2a; 3 payload words then trailer {14'h2AAA,10'd12,4'hA,12'h1AA} -> ram_waddr 0..3, ch_words=4, ch_err=0, ch_done one pulse, con_busy=1 until ch_ack.
- Address mismatch: same stream with trailer addr 12'h1AB -> ch_err=4'b0010, err_cnt=1, err_sticky=4'b0010. Repeat with the macro undefined -> ch_err=0.
- Overflow: ADDR_W=4, 20 strobes -> exactly 16 writes, ch_words=16, ch_err[3]=1.
- Last strobe coincides with trsfn rise -> that word is written, ch_words includes it.
- altro_chrdo_en dropped mid-XFER after 2 words -> no ch_done, con_busy stays 0, IDLE the next cycle. A following ram_addrclr restarts at address 0.
- ch_ack coincident with DONE -> con_busy=1. err_clr coincident with an erroneous DONE -> err_cnt=0 and err_sticky=0.
